// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream big-endian into 32-bit words,
// appends 0x80, zero fill and the 64-bit bit length, and emits 16-word blocks
// over a valid/ready word handshake.
module sha256_msg_padder #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        in_empty,
    output logic        in_ready,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_first,
    output logic        word_eob,
    output logic        word_eom
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        PAD    = 2'd1,
        LEN_HI = 2'd2,
        LEN_LO = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [CNT_W-1:0] byte_cnt;
    logic [1:0]       byte_idx;
    logic [3:0]       wcnt;
    logic [23:0]      asm_reg;
    logic             pad_done;

    logic             out_free;
    logic             in_acc;
    logic             byte_wr;
    logic [7:0]       byte_val;
    logic             pad_end;
    logic             ld_hi;
    logic             ld_lo;
    logic             msg_done;
    logic [63:0]      msg_len;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_acc && in_last) state_nxt = PAD;
            PAD:     if (pad_end) state_nxt = LEN_HI;
            LEN_HI:  if (out_free) state_nxt = LEN_LO;
            LEN_LO:  if (msg_done) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Handshake, byte-source and word-load strobes decoded from state
    always_comb begin
        out_free = !word_valid || word_ready;
        in_ready = (state == LOAD) && out_free && !rst;
        in_acc   = in_valid && in_ready;
        pad_end  = pad_done && (byte_idx == 2'd0) && (wcnt == 4'd14);
        msg_len  = 64'(byte_cnt) << 3;
        byte_wr  = 1'b0;
        byte_val = 8'h00;
        ld_hi    = 1'b0;
        ld_lo    = 1'b0;
        msg_done = 1'b0;
        case (state)
            LOAD: begin
                byte_wr  = in_acc && !in_empty;
                byte_val = in_data;
            end
            PAD: begin
                byte_wr  = out_free && !pad_end;
                byte_val = pad_done ? 8'h00 : 8'h80;
            end
            LEN_HI: begin
                ld_hi = out_free;
            end
            LEN_LO: begin
                // word_eom marks that the length-low word is already presented;
                // its handshake ends the message, otherwise load it.
                msg_done = word_valid && word_eom && word_ready;
                ld_lo    = out_free && !(word_valid && word_eom);
            end
            default: ;
        endcase
    end

    // Output word register: loaded from the assembled word or the length field
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_data  <= '0;
            word_valid <= 1'b0;
            word_first <= 1'b0;
            word_eob   <= 1'b0;
            word_eom   <= 1'b0;
        end else begin
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (byte_wr && (byte_idx == 2'd3)) begin
                word_data  <= {asm_reg, byte_val};
                word_valid <= 1'b1;
                word_first <= (wcnt == 4'd0);
                word_eob   <= (wcnt == 4'd15);
                word_eom   <= 1'b0;
            end
            if (ld_hi) begin
                word_data  <= msg_len[63:32];
                word_valid <= 1'b1;
                word_first <= 1'b0;
                word_eob   <= 1'b0;
                word_eom   <= 1'b0;
            end
            if (ld_lo) begin
                word_data  <= msg_len[31:0];
                word_valid <= 1'b1;
                word_first <= 1'b0;
                word_eob   <= 1'b1;
                word_eom   <= 1'b1;
            end
        end
    end

    // Byte assembly, byte/word counters and pad-marker tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            byte_idx <= '0;
            wcnt     <= '0;
            asm_reg  <= '0;
            pad_done <= 1'b0;
        end else if (msg_done) begin
            byte_cnt <= '0;
            byte_idx <= '0;
            wcnt     <= '0;
            asm_reg  <= '0;
            pad_done <= 1'b0;
        end else begin
            if (byte_wr) begin
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    wcnt <= wcnt + 4'd1;
                end else begin
                    asm_reg <= {asm_reg[15:0], byte_val};
                end
            end
            if (byte_wr && (state == LOAD)) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
            if (byte_wr && (state == PAD)) begin
                pad_done <= 1'b1;
            end
            if (ld_hi || ld_lo) begin
                wcnt <= wcnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: reference padding model, spot
// constants, backpressure stability and reset abort.
module tb_sha256_msg_padder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_empty;
    logic        in_ready;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        word_first;
    logic        word_eob;
    logic        word_eom;

    sha256_msg_padder #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_empty   (in_empty),
        .in_ready   (in_ready),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_first (word_first),
        .word_eob   (word_eob),
        .word_eom   (word_eom)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          stall_err = 0;
    int          ir_err    = 0;
    int          stall_cnt = 0;
    bit          bp_en = 1'b0;
    logic [34:0] q[$];
    logic [7:0]  msg[0:127];
    logic        prev_stall = 1'b0;
    logic [34:0] prev_w;

    // word_ready driver: always high unless random backpressure is enabled
    initial begin
        word_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            word_ready = bp_en ? ($urandom_range(0, 99) >= 40) : 1'b1;
        end
    end

    // Output monitor: capture handshaken words and watch stall behaviour
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!word_valid || {word_eom, word_eob, word_first, word_data} !== prev_w))
                stall_err++;
            if (word_valid && !word_ready) begin
                stall_cnt++;
                if (in_ready) ir_err++;
            end
            if (word_valid && word_ready)
                q.push_back({word_eom, word_eob, word_first, word_data});
            prev_stall = word_valid && !word_ready;
            prev_w     = {word_eom, word_eob, word_first, word_data};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
        bit acc;
        acc      = 1'b0;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        in_valid = 1'b1;
        for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
        check("beat_accepted", 64'(acc), 64'd1);
    endtask

    task automatic send_msg(input int n, input bit term_empty);
        for (int i = 0; i < n; i++)
            send_beat(msg[i], (i == n - 1) && !term_empty, 1'b0);
        if (n == 0 || term_empty)
            send_beat(8'h00, 1'b1, 1'b1);
    endtask

    task automatic wait_words(input int n);
        for (int t = 0; t < 4000 && q.size() < n; t++)
            @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        check("word_count", 64'(q.size()), 64'(n));
    endtask

    // Reference padded byte p of an n-byte message padded to L bytes
    function automatic logic [7:0] exp_byte(input int n, input int p, input int L);
        logic [63:0] bits;
        bits = 64'(n) << 3;
        if (p < n)       return msg[p];
        if (p == n)      return 8'h80;
        if (p >= L - 8)  return 8'(bits >> (8 * (L - 1 - p)));
        return 8'h00;
    endfunction

    task automatic check_msg(input string name, input int n);
        int L;
        int nw;
        logic [31:0] ew;
        L  = ((n + 9 + 63) / 64) * 64;
        nw = L / 4;
        for (int w = 0; w < nw && w < q.size(); w++) begin
            ew = {exp_byte(n, 4*w, L), exp_byte(n, 4*w+1, L),
                  exp_byte(n, 4*w+2, L), exp_byte(n, 4*w+3, L)};
            check($sformatf("%s_w%0d_data", name, w), 64'(q[w][31:0]), 64'(ew));
            check($sformatf("%s_w%0d_first", name, w), 64'(q[w][32]), 64'((w % 16) == 0));
            check($sformatf("%s_w%0d_eob", name, w), 64'(q[w][33]), 64'((w % 16) == 15));
            check($sformatf("%s_w%0d_eom", name, w), 64'(q[w][34]), 64'(w == nw - 1));
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_word_valid", 64'(word_valid), 64'd0);
        check("rst_word_data", 64'(word_data), 64'd0);
        check("rst_flags", 64'({word_first, word_eob, word_eom}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // "abc"
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        send_msg(3, 1'b0);
        check("pad_in_ready", 64'(in_ready), 64'd0);
        wait_words(16);
        check_msg("abc", 3);
        check("abc_w0", 64'(q[0][31:0]), 64'h61626380);
        check("abc_w15", 64'(q[15][31:0]), 64'h00000018);
        q.delete();

        // empty message
        send_msg(0, 1'b0);
        wait_words(16);
        check_msg("empty", 0);
        check("empty_w0", 64'(q[0][31:0]), 64'h80000000);
        check("empty_w15_eom", 64'(q[15][34]), 64'd1);
        q.delete();

        // 55 bytes, with a stray in_empty beat (no in_last) mid-message
        for (int i = 0; i < 55; i++) msg[i] = 8'h41;
        for (int i = 0; i < 55; i++) begin
            if (i == 20) send_beat(8'h00, 1'b0, 1'b1);
            send_beat(msg[i], i == 54, 1'b0);
            if (i == 2) check("lat_before_4th", 64'(word_valid), 64'd0);
            if (i == 3) begin
                check("lat_valid_after_4th", 64'(word_valid), 64'd1);
                check("lat_data_after_4th", 64'(word_data), 64'h41414141);
            end
        end
        wait_words(16);
        check_msg("b55", 55);
        check("b55_w13", 64'(q[13][31:0]), 64'h41414180);
        check("b55_w15", 64'(q[15][31:0]), 64'h000001B8);
        q.delete();

        // 56 bytes, terminated by a separate empty in_last beat
        for (int i = 0; i < 56; i++) msg[i] = 8'h41;
        send_msg(56, 1'b1);
        wait_words(32);
        check_msg("b56", 56);
        check("b56_w14", 64'(q[14][31:0]), 64'h80000000);
        check("b56_w15_eob", 64'(q[15][33]), 64'd1);
        check("b56_w15_eom", 64'(q[15][34]), 64'd0);
        check("b56_w31", 64'(q[31][31:0]), 64'h000001C0);
        q.delete();

        // 64 bytes under random backpressure
        for (int i = 0; i < 64; i++) msg[i] = 8'(i);
        bp_en = 1'b1;
        send_msg(64, 1'b0);
        for (int t = 0; t < 4000 && q.size() < 32; t++)
            @(posedge clk);
        bp_en = 1'b0;
        wait_words(32);
        check_msg("b64", 64);
        check("b64_w16", 64'(q[16][31:0]), 64'h80000000);
        check("b64_w31", 64'(q[31][31:0]), 64'h00000200);
        check("bp_stalls_seen", 64'(stall_cnt > 0), 64'd1);
        check("bp_data_stable", 64'(stall_err), 64'd0);
        check("bp_in_ready_low", 64'(ir_err), 64'd0);
        q.delete();

        // reset after 10 of 20 bytes, then "abc"
        for (int i = 0; i < 20; i++) msg[i] = 8'h30 + 8'(i);
        for (int i = 0; i < 10; i++) send_beat(msg[i], 1'b0, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        check("abort_rst_in_ready", 64'(in_ready), 64'd0);
        check("abort_rst_valid", 64'(word_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        send_msg(3, 1'b0);
        wait_words(16);
        check_msg("abort_abc", 3);
        check("abort_abc_w0", 64'(q[0][31:0]), 64'h61626380);
        check("abort_abc_w15", 64'(q[15][31:0]), 64'h00000018);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
